// File: rtl/sync_sample_fifo.sv
// Single-clock sample FIFO: DEPTH-entry storage array plus a registered
// first-word-fall-through output stage, level/threshold flags and sticky overflow.
module sync_sample_fifo #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 4,
    parameter int ALMOST_FULL_LEVEL  = 12,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     write_valid,
    output logic                     write_ready,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic                     read_valid,
    input  logic                     read_ready,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic [ADDRESS_WIDTH:0]   level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int LW    = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] CAPACITY = LW'(DEPTH + 1);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH:0]   store_count;
    logic                     store_empty;
    logic                     full;
    logic                     write_accept;
    logic                     read_accept;
    logic                     refused;
    logic                     load_out;
    logic                     bypass;
    logic                     store_write;

    // Storage holds every word except the one sitting in the output register.
    assign store_count  = level - LW'(read_valid);
    assign store_empty  = (store_count == '0);
    assign full         = (level == CAPACITY);

    assign write_ready  = reset_n & ~full;
    assign write_accept = write_valid & write_ready & ~flush;
    assign read_accept  = read_valid & read_ready & ~flush;
    assign refused      = write_valid & ~write_ready & ~flush;

    assign load_out     = ~read_valid | read_accept;
    assign bypass       = load_out & store_empty;
    assign store_write  = write_accept & ~bypass;

    assign almost_full  = 32'(level) >= ALMOST_FULL_LEVEL;
    assign almost_empty = 32'(level) <= ALMOST_EMPTY_LEVEL;

    always_ff @(posedge clock) begin
        if (store_write) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (refused) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                read_valid <= 1'b0;
            end else begin
                if (load_out) begin
                    if (!store_empty) begin
                        read_data  <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + 1'b1;
                        read_valid <= 1'b1;
                    end else if (write_accept) begin
                        read_data  <= write_data;
                        read_valid <= 1'b1;
                    end else begin
                        read_valid <= 1'b0;
                    end
                end

                if (store_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end

                case ({write_accept, read_accept})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
        end
    end

endmodule
